// File: rtl/nrisc_pkg.sv
// Shared defaults and elaboration-time helpers for the nrisc register bank.
// No logic; constants and a ceil-log2 used to size address and count fields.
package nrisc_pkg;
  localparam int TAM_DEF  = 16;
  localparam int NREG_DEF = 16;

  // Ceil(log2(v)), never below 1 so a one-entry field still has a bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction
endpackage

// File: rtl/nrisc_scoreboard.sv
// Load-pending scoreboard: busy bitmap, population count, per-read-port busy lookup.
// Busy updates take effect one edge after pend_set/wb_en; lookups are combinational.
module nrisc_scoreboard
  import nrisc_pkg::*;
#(
  parameter int NREG    = NREG_DEF,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1,
  localparam int AW     = clog2(NREG),
  localparam int CW     = clog2(NREG + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pend_set,
  input  logic [AW-1:0] pend_addr,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [AW-1:0] rd1_addr,
  input  logic [AW-1:0] rd2_addr,
  output logic          rd1_busy,
  output logic          rd2_busy,
  output logic [CW-1:0] pend_cnt
);
  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   pend_cnt_q, pend_cnt_d;
  logic            pend_ok;

  always_comb begin
    pend_ok = pend_set && !((ZERO_R0 != 0) && (pend_addr == '0));
    busy_d  = busy_q;
    if (wb_en)   busy_d[wb_addr]   = 1'b0;
    // A new load issued in the same cycle as the old one returns keeps the register busy.
    if (pend_ok) busy_d[pend_addr] = 1'b1;
    pend_cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      pend_cnt_d = pend_cnt_d + CW'(busy_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign rd1_busy = ((BYPASS != 0) && wb_en && (wb_addr == rd1_addr)) ? 1'b0 : busy_q[rd1_addr];
  assign rd2_busy = ((BYPASS != 0) && wb_en && (wb_addr == rd2_addr)) ? 1'b0 : busy_q[rd2_addr];
  assign pend_cnt = pend_cnt_q;
endmodule

// File: rtl/nrisc_regbank.sv
// Two-read / two-write register file with optional write forwarding and load scoreboard.
// Reads are zero-latency combinational, writes commit next edge; no backpressure, stall is advisory.
module nrisc_regbank
  import nrisc_pkg::*;
#(
  parameter int TAM                 = TAM_DEF,
  parameter int NREG                = NREG_DEF,
  parameter int ZERO_R0             = 1,
  parameter int BYPASS              = 1,
  parameter logic [TAM-1:0] RST_VAL = '0,
  localparam int AW                 = clog2(NREG),
  localparam int CW                 = clog2(NREG + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [AW-1:0]  CORE_REG_RF1,
  input  logic [AW-1:0]  CORE_REG_RF2,
  output logic [TAM-1:0] RF1,
  output logic [TAM-1:0] RF2,
  input  logic           wa_en,
  input  logic [AW-1:0]  wa_addr,
  input  logic [TAM-1:0] wa_data,
  input  logic           wb_en,
  input  logic [AW-1:0]  wb_addr,
  input  logic [TAM-1:0] wb_data,
  input  logic           pend_set,
  input  logic [AW-1:0]  pend_addr,
  output logic           RF1_busy,
  output logic           RF2_busy,
  output logic           stall,
  output logic [CW-1:0]  pend_cnt,
  output logic           collision
);
  logic [TAM-1:0] regs_q [NREG];
  logic [TAM-1:0] regs_d [NREG];
  logic           collision_q, collision_d;
  logic           wa_ok, wb_ok;

  always_comb begin
    wa_ok = wa_en && !((ZERO_R0 != 0) && (wa_addr == '0));
    wb_ok = wb_en && !((ZERO_R0 != 0) && (wb_addr == '0));
    regs_d = regs_q;
    if (wa_ok) regs_d[wa_addr] = wa_data;
    if (wb_ok) regs_d[wb_addr] = wb_data;
    collision_d = wa_ok && wb_ok && (wa_addr == wb_addr);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= RST_VAL;
      collision_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      collision_q <= collision_d;
    end
  end

  // Load return (B) is the younger result, so it outranks the ALU write when forwarding.
  function automatic logic [TAM-1:0] rd_mux(input logic [AW-1:0] a);
    if ((ZERO_R0 != 0) && (a == '0))                return '0;
    if ((BYPASS != 0) && wb_ok && (wb_addr == a))   return wb_data;
    if ((BYPASS != 0) && wa_ok && (wa_addr == a))   return wa_data;
    return regs_q[a];
  endfunction

  assign RF1       = rd_mux(CORE_REG_RF1);
  assign RF2       = rd_mux(CORE_REG_RF2);
  assign collision = collision_q;
  assign stall     = RF1_busy | RF2_busy;

  nrisc_scoreboard #(
    .NREG    (NREG),
    .ZERO_R0 (ZERO_R0),
    .BYPASS  (BYPASS)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .rd1_addr  (CORE_REG_RF1),
    .rd2_addr  (CORE_REG_RF2),
    .rd1_busy  (RF1_busy),
    .rd2_busy  (RF2_busy),
    .pend_cnt  (pend_cnt)
  );
endmodule

// File: tb/tb_nrisc_regbank.sv
// Bench for nrisc_regbank: directed scenarios plus randomized traffic against a
// register/busy array model; a BYPASS=0 instance shares all inputs.
module tb_nrisc_regbank;
  localparam int TAM  = 16;
  localparam int NREG = 16;
  localparam int AW   = 4;
  localparam int CW   = 5;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0]  rf1_addr, rf2_addr, wa_addr, wb_addr, pend_addr;
  logic [TAM-1:0] wa_data, wb_data;
  logic           wa_en, wb_en, pend_set;

  logic [TAM-1:0] rf1, rf2, nb_rf1, nb_rf2;
  logic           rf1_busy, rf2_busy, stall, collision;
  logic           nb_rf1_busy, nb_rf2_busy, nb_stall, nb_collision;
  logic [CW-1:0]  pend_cnt, nb_pend_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [TAM-1:0] mregs [NREG];
  bit             mbusy [NREG];
  bit             mcoll;

  always #5 clk = ~clk;

  nrisc_regbank #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .CORE_REG_RF1(rf1_addr), .CORE_REG_RF2(rf2_addr),
    .RF1(rf1), .RF2(rf2), .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .pend_set(pend_set),
    .pend_addr(pend_addr), .RF1_busy(rf1_busy), .RF2_busy(rf2_busy), .stall(stall),
    .pend_cnt(pend_cnt), .collision(collision)
  );

  nrisc_regbank #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .CORE_REG_RF1(rf1_addr), .CORE_REG_RF2(rf2_addr),
    .RF1(nb_rf1), .RF2(nb_rf2), .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .pend_set(pend_set),
    .pend_addr(pend_addr), .RF1_busy(nb_rf1_busy), .RF2_busy(nb_rf2_busy), .stall(nb_stall),
    .pend_cnt(nb_pend_cnt), .collision(nb_collision)
  );

  function automatic int mcount();
    int c = 0;
    for (int i = 0; i < NREG; i++) c += int'(mbusy[i]);
    return c;
  endfunction

  function automatic logic [TAM-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && wb_en && wb_addr == a) return wb_data;
    if (byp && wa_en && wa_addr == a) return wa_data;
    return mregs[a];
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a, input bit byp);
    if (byp && wb_en && wb_addr == a) return 1'b0;
    return mbusy[a];
  endfunction

  task automatic idle();
    wa_en = 0; wb_en = 0; pend_set = 0;
    wa_addr = 0; wb_addr = 0; pend_addr = 0; wa_data = 0; wb_data = 0;
  endtask

  // One rising edge; the model absorbs whatever the inputs held at that edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin mregs[i] = '0; mbusy[i] = 0; end
      mcoll = 0;
    end else begin
      mcoll = wa_en && wb_en && (wa_addr == wb_addr) && (wa_addr != 0);
      if (wa_en && wa_addr != 0) mregs[wa_addr] = wa_data;
      if (wb_en && wb_addr != 0) mregs[wb_addr] = wb_data;
      if (wb_en) mbusy[wb_addr] = 0;
      if (pend_set && pend_addr != 0) mbusy[pend_addr] = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 0; idle(); rf1_addr = 0; rf2_addr = 0;
    tick(); tick();
    rst = 1;
    for (int i = 0; i < NREG; i++) begin
      rf1_addr = AW'(i); rf2_addr = AW'(NREG - 1 - i);
      #1;
      n_checks++; if (rf1 !== 16'h0) $display("FAIL reset_rf1[%0d] got %h want 0", i, rf1); else n_pass++;
      n_checks++; if (rf2 !== 16'h0) $display("FAIL reset_rf2[%0d] got %h want 0", i, rf2); else n_pass++;
    end
    n_checks++; if (pend_cnt !== 5'd0) $display("FAIL reset_pend_cnt got %0d want 0", pend_cnt); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else n_pass++;
    n_checks++; if (collision !== 1'b0) $display("FAIL reset_collision got %b want 0", collision); else n_pass++;
  endtask

  task automatic test_bypass();
    idle(); rf1_addr = 3; rf2_addr = 0;
    wa_en = 1; wa_addr = 3; wa_data = 16'h1234;
    #1;
    n_checks++; if (rf1 !== 16'h1234) $display("FAIL bypass_rf1 got %h want 1234", rf1); else n_pass++;
    n_checks++; if (nb_rf1 !== 16'h0) $display("FAIL nobypass_rf1 got %h want 0", nb_rf1); else n_pass++;
    tick(); idle(); #1;
    n_checks++; if (nb_rf1 !== 16'h1234) $display("FAIL nobypass_rf1_next got %h want 1234", nb_rf1); else n_pass++;
    n_checks++; if (rf1 !== 16'h1234) $display("FAIL bypass_rf1_next got %h want 1234", rf1); else n_pass++;
  endtask

  task automatic test_collision();
    idle(); rf1_addr = 5;
    wa_en = 1; wa_addr = 5; wa_data = 16'hAAAA;
    wb_en = 1; wb_addr = 5; wb_data = 16'h5555;
    #1;
    n_checks++; if (rf1 !== 16'h5555) $display("FAIL coll_bypass_prio got %h want 5555", rf1); else n_pass++;
    n_checks++; if (collision !== 1'b0) $display("FAIL coll_early got %b want 0", collision); else n_pass++;
    tick(); idle(); #1;
    n_checks++; if (collision !== 1'b1) $display("FAIL coll_pulse got %b want 1", collision); else n_pass++;
    n_checks++; if (rf1 !== 16'h5555) $display("FAIL coll_reg5 got %h want 5555", rf1); else n_pass++;
    tick();
    n_checks++; if (collision !== 1'b0) $display("FAIL coll_one_cycle got %b want 0", collision); else n_pass++;
  endtask

  task automatic test_pending();
    idle(); rf1_addr = 0; rf2_addr = 7;
    pend_set = 1; pend_addr = 7;
    tick(); idle(); #1;
    n_checks++; if (stall !== 1'b1) $display("FAIL pend_stall got %b want 1", stall); else n_pass++;
    n_checks++; if (pend_cnt !== 5'd1) $display("FAIL pend_cnt_set got %0d want 1", pend_cnt); else n_pass++;
    wb_en = 1; wb_addr = 7; wb_data = 16'h00FF;
    #1;
    n_checks++; if (rf2_busy !== 1'b0) $display("FAIL pend_busy_bypass got %b want 0", rf2_busy); else n_pass++;
    n_checks++; if (rf2 !== 16'h00FF) $display("FAIL pend_rf2 got %h want 00ff", rf2); else n_pass++;
    n_checks++; if (nb_rf2_busy !== 1'b1) $display("FAIL pend_nb_busy got %b want 1", nb_rf2_busy); else n_pass++;
    tick(); idle(); #1;
    n_checks++; if (pend_cnt !== 5'd0) $display("FAIL pend_cnt_clear got %0d want 0", pend_cnt); else n_pass++;
    n_checks++; if (rf2 !== 16'h00FF || stall !== 1'b0) $display("FAIL pend_after got %h/%b want 00ff/0", rf2, stall); else n_pass++;
  endtask

  task automatic test_race();
    idle(); rf1_addr = 4; rf2_addr = 0;
    pend_set = 1; pend_addr = 4;
    tick();
    wb_en = 1; wb_addr = 4; wb_data = 16'hC0DE;
    tick(); idle(); #1;
    n_checks++; if (rf1_busy !== 1'b1) $display("FAIL race_busy got %b want 1", rf1_busy); else n_pass++;
    n_checks++; if (pend_cnt !== 5'd1) $display("FAIL race_cnt got %0d want 1", pend_cnt); else n_pass++;
    n_checks++; if (rf1 !== 16'hC0DE) $display("FAIL race_data got %h want c0de", rf1); else n_pass++;
    wa_en = 1; wa_addr = 4; wa_data = 16'h4444;
    tick(); idle(); #1;
    n_checks++; if (rf1 !== 16'h4444 || rf1_busy !== 1'b1) $display("FAIL alu_on_busy got %h/%b want 4444/1", rf1, rf1_busy); else n_pass++;
    wb_en = 1; wb_addr = 4; wb_data = 16'h0004;
    tick(); idle(); #1;
    n_checks++; if (pend_cnt !== 5'd0) $display("FAIL race_cleanup got %0d want 0", pend_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    idle(); rf1_addr = 10; rf2_addr = 9;
    pend_set = 1; pend_addr = 9;
    tick(); idle();
    wb_en = 1; wb_addr = 10; wb_data = 16'h0BAD;
    tick(); idle(); #1;
    n_checks++; if (pend_cnt !== 5'd1) $display("FAIL wb_nonbusy_cnt got %0d want 1", pend_cnt); else n_pass++;
    n_checks++; if (rf1 !== 16'h0BAD) $display("FAIL wb_nonbusy_data got %h want 0bad", rf1); else n_pass++;
    pend_set = 1; pend_addr = 9;
    tick(); idle(); #1;
    n_checks++; if (pend_cnt !== 5'd1) $display("FAIL repend_cnt got %0d want 1", pend_cnt); else n_pass++;
    // Zero register: write, pend and collision all suppressed.
    rf1_addr = 0;
    wa_en = 1; wa_addr = 0; wa_data = 16'hFFFF;
    wb_en = 1; wb_addr = 0; wb_data = 16'hEEEE;
    pend_set = 1; pend_addr = 0;
    #1;
    n_checks++; if (rf1 !== 16'h0) $display("FAIL r0_bypass got %h want 0", rf1); else n_pass++;
    tick(); idle(); #1;
    n_checks++; if (collision !== 1'b0) $display("FAIL r0_collision got %b want 0", collision); else n_pass++;
    n_checks++; if (rf1 !== 16'h0 || pend_cnt !== 5'd1) $display("FAIL r0_state got %h/%0d want 0/1", rf1, pend_cnt); else n_pass++;
  endtask

  task automatic test_mid_reset();
    idle(); rf1_addr = 2; rf2_addr = 6;
    for (int i = 1; i < NREG; i++) begin
      pend_set = 1; pend_addr = AW'(i);
      tick();
    end
    idle(); #1;
    n_checks++; if (pend_cnt !== 5'd15) $display("FAIL full_cnt got %0d want 15", pend_cnt); else n_pass++;
    pend_set = 1; pend_addr = 3;
    tick(); idle(); #1;
    n_checks++; if (pend_cnt !== 5'd15) $display("FAIL full_repend got %0d want 15", pend_cnt); else n_pass++;
    rst = 0; wa_en = 1; wa_addr = 6; wa_data = 16'hBEEF; pend_set = 1; pend_addr = 2;
    tick(); rst = 1; idle(); #1;
    n_checks++; if (pend_cnt !== 5'd0) $display("FAIL midrst_cnt got %0d want 0", pend_cnt); else n_pass++;
    n_checks++; if (rf1_busy !== 1'b0 || stall !== 1'b0) $display("FAIL midrst_busy got %b/%b want 0/0", rf1_busy, stall); else n_pass++;
    n_checks++; if (rf2 !== 16'h0) $display("FAIL midrst_write_dropped got %h want 0", rf2); else n_pass++;
    rf1_addr = 0; wa_en = 1; wa_addr = 0; wa_data = 16'h7777;
    tick(); idle(); #1;
    n_checks++; if (rf1 !== 16'h0) $display("FAIL midrst_r0 got %h want 0", rf1); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 49) != 0);
      rf1_addr  = AW'($urandom_range(0, NREG - 1));
      rf2_addr  = AW'($urandom_range(0, NREG - 1));
      wa_en     = ($urandom_range(0, 1) != 0);
      wa_addr   = AW'($urandom_range(0, NREG - 1));
      wa_data   = TAM'($urandom);
      wb_en     = ($urandom_range(0, 2) == 0);
      wb_addr   = ($urandom_range(0, 3) == 0) ? wa_addr : AW'($urandom_range(0, NREG - 1));
      wb_data   = TAM'($urandom);
      pend_set  = ($urandom_range(0, 2) == 0);
      pend_addr = ($urandom_range(0, 3) == 0) ? wb_addr : AW'($urandom_range(0, NREG - 1));
      #1;
      n_checks++; if (rf1 !== exp_rd(rf1_addr, 1) || rf2 !== exp_rd(rf2_addr, 1))
        $display("FAIL rnd_read c=%0d got %h/%h want %h/%h", c, rf1, rf2, exp_rd(rf1_addr, 1), exp_rd(rf2_addr, 1)); else n_pass++;
      n_checks++; if (nb_rf1 !== exp_rd(rf1_addr, 0) || nb_rf2 !== exp_rd(rf2_addr, 0))
        $display("FAIL rnd_read_nb c=%0d got %h/%h want %h/%h", c, nb_rf1, nb_rf2, exp_rd(rf1_addr, 0), exp_rd(rf2_addr, 0)); else n_pass++;
      n_checks++; if (rf1_busy !== exp_busy(rf1_addr, 1) || rf2_busy !== exp_busy(rf2_addr, 1) ||
                      stall !== (exp_busy(rf1_addr, 1) | exp_busy(rf2_addr, 1)))
        $display("FAIL rnd_busy c=%0d got %b%b%b", c, rf1_busy, rf2_busy, stall); else n_pass++;
      n_checks++; if (nb_rf1_busy !== exp_busy(rf1_addr, 0) || nb_rf2_busy !== exp_busy(rf2_addr, 0) ||
                      nb_stall !== (exp_busy(rf1_addr, 0) | exp_busy(rf2_addr, 0)))
        $display("FAIL rnd_busy_nb c=%0d got %b%b%b", c, nb_rf1_busy, nb_rf2_busy, nb_stall); else n_pass++;
      n_checks++; if (int'(pend_cnt) != mcount() || int'(nb_pend_cnt) != mcount())
        $display("FAIL rnd_pend_cnt c=%0d got %0d/%0d want %0d", c, pend_cnt, nb_pend_cnt, mcount()); else n_pass++;
      n_checks++; if (collision !== mcoll || nb_collision !== mcoll)
        $display("FAIL rnd_collision c=%0d got %b/%b want %b", c, collision, nb_collision, mcoll); else n_pass++;
      tick();
    end
    rst = 1; idle();
  endtask

  initial begin
    rst = 0; idle(); rf1_addr = 0; rf2_addr = 0; mcoll = 0;
    for (int i = 0; i < NREG; i++) begin mregs[i] = '0; mbusy[i] = 0; end
    test_reset();
    test_bypass();
    test_collision();
    test_pending();
    test_race();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
